super_register_n: RTL
=====================

Name: super_register_n

Overview:
Parametrised successor to the 4-bit mode-select universal register, generalised to WIDTH bits. Mode encodings 0-7 are unchanged, so existing MUX-based FSM tops drop in with mode[3]=0. It adds rotate, arithmetic shift, invert, a programmable terminal (modulus) register, modulo up/down counting, optional saturation, and registered carry, shift-out and terminal-count flags. Used as the state/count element in the MuxBasedFSMs designs.

Parameters:
WIDTH, 4, register width in bits; must be >= 2.
SATURATE, 0, 0 = INC/DEC wrap modulo 2^WIDTH; 1 = INC/DEC clamp at all-ones/zero.
RESET_VAL, 0, value of q after reset (WIDTH bits).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  1 = execute mode this cycle; 0 = hold everything, flags cleared
s  input  4  mode select (see Behaviour)
load  input  WIDTH  parallel data for LOAD / LDTERM
rsi  input  1  serial in to MSB for SHR
lsi  input  1  serial in to LSB for SHL
q  output  WIDTH  register contents
term  output  WIDTH  terminal/modulus register
tc  output  1  combinational: q == term
co  output  1  registered 1-cycle pulse: wrap or clamp occurred on last edge
sout  output  1  registered bit shifted out by last SHR/SHL/ASR; else 0

Behaviour:
- Reset (rst_n low, async): q=RESET_VAL, term=all-ones, co=0, sout=0. Outputs stay at these values while rst_n is low. Reset dominates any clock edge. The first operation executes on the first rising edge after rst_n deasserts.
- All state updates happen on the rising clk edge with en=1. Latency is 1 cycle from s/load to q.
- en=0: q and term hold; co=0, sout=0 on that edge.
- co and sout default to 0 on every edge unless the executed mode sets them.
- Modes (s):
  - 0 LOAD: q=load.
  - 1 DEC: q=q-1. At q=0: SATURATE=0 gives all-ones; SATURATE=1 holds 0. co=1 in both cases.
  - 2 INC: q=q+1. At q=all-ones: SATURATE=0 gives 0; SATURATE=1 holds all-ones. co=1 in both cases.
  - 3 SET: q=all-ones.
  - 4 CLR: q=0.
  - 5 SHR: q={rsi,q[W-1:1]}, sout=q[0].
  - 6 SHL: q={q[W-2:0],lsi}, sout=q[W-1].
  - 7 HOLD: no change.
  - 8 ROR: q={q[0],q[W-1:1]}.
  - 9 ROL: q={q[W-2:0],q[W-1]}.
  - 10 ASR: q={q[W-1],q[W-1:1]}, sout=q[0].
  - 11 INV: q=~q.
  - 12 LDTERM: term=load; q unchanged.
  - 13 MODUP: if q==term then q=0 and co=1, else q=q+1. If q>term it counts up and wraps at all-ones to 0 with co=1. SATURATE is ignored.
  - 14 MODDN: if q==0 then q=term and co=1, else q=q-1. SATURATE is ignored.
  - 15 HOLD (reserved): no change.
- term changes only in mode 12 or on reset.
- tc is purely combinational from the registered q and term, with no extra latency.
- All arithmetic is unsigned, WIDTH bits, with no carry beyond co.
- Reset asserted mid-count or mid-shift aborts the operation. No partial update is visible afterwards.
- Unknown or X on s must not corrupt term. The implementation uses a full case with a default of hold.

Test Plan:
1. WIDTH=8, reset -> q=0x00, term=0xFF, co=0, sout=0, tc=0. Then s=0, load=0xA5, one edge -> q=0xA5.
2. SATURATE=0: load 0xFE, s=2 for 3 edges -> q=0xFF, 0x00 (co=1 on that edge only), 0x01. SATURATE=1, same stimulus -> q=0xFF, 0xFF (co=1), 0xFF (co=1).
3. Load 0x81. s=5 with rsi=1 -> q=0xC0, sout=1. Then s=10 -> q=0xE0, sout=0. Then s=9 -> q=0xC1. Then s=6 with lsi=0 -> q=0x82, sout=1.
4. s=12 with load=0x04, then load q=0. s=13 for 6 edges -> q=1,2,3,4,0,1. co=1 only on the 4->0 edge; tc=1 while q=4. Then s=14 from q=1 -> q=0, then 4 with co=1.
5. en=0 with s=2 for 3 edges -> q unchanged, co=0. Reset pulsed asynchronously mid-cycle during s=13 counting -> q=0 and term=0xFF immediately, before the next clk edge.
6. Legacy compatibility, WIDTH=4: sweep s=0..7 from q=0x6 with load=0x9, rsi=1, lsi=0 -> q=0x9, 0x5, 0x7, 0xF, 0x0, 0xB, 0xC, 0x6 respectively, each from fresh q=0x6.

Source files
------------

// File: rtl/super_register_n.sv
// super_register_n: WIDTH-bit universal register with shift, rotate, modulo count.
// Ports: clk, rst_n, en, s[3:0], load, rsi, lsi -> q, term, tc, co, sout.
module super_register_n #(
  parameter int WIDTH = 4,
  parameter bit SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       s,
  input  logic [WIDTH-1:0] load,
  input  logic             rsi,
  input  logic             lsi,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] term,
  output logic             tc,
  output logic             co,
  output logic             sout
);

  localparam logic [3:0] M_LOAD = 4'd0;
  localparam logic [3:0] M_DEC  = 4'd1;
  localparam logic [3:0] M_INC  = 4'd2;
  localparam logic [3:0] M_SET  = 4'd3;
  localparam logic [3:0] M_CLR  = 4'd4;
  localparam logic [3:0] M_SHR  = 4'd5;
  localparam logic [3:0] M_SHL  = 4'd6;
  localparam logic [3:0] M_HOLD = 4'd7;
  localparam logic [3:0] M_ROR  = 4'd8;
  localparam logic [3:0] M_ROL  = 4'd9;
  localparam logic [3:0] M_ASR  = 4'd10;
  localparam logic [3:0] M_INV  = 4'd11;
  localparam logic [3:0] M_LDT  = 4'd12;
  localparam logic [3:0] M_MUP  = 4'd13;
  localparam logic [3:0] M_MDN  = 4'd14;

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] term_n;
  logic             co_n;
  logic             sout_n;

  assign tc = (q == term);

  always_comb begin
    q_n    = q;
    term_n = term;
    co_n   = 1'b0;
    sout_n = 1'b0;
    if (en) begin
      case (s)
        M_LOAD: q_n = load;
        M_DEC: begin
          if (q == ZERO) begin
            co_n = 1'b1;
            q_n  = SATURATE ? ZERO : ONES;
          end else begin
            q_n = q - ONE;
          end
        end
        M_INC: begin
          if (q == ONES) begin
            co_n = 1'b1;
            q_n  = SATURATE ? ONES : ZERO;
          end else begin
            q_n = q + ONE;
          end
        end
        M_SET: q_n = ONES;
        M_CLR: q_n = ZERO;
        M_SHR: begin
          q_n    = {rsi, q[WIDTH-1:1]};
          sout_n = q[0];
        end
        M_SHL: begin
          q_n    = {q[WIDTH-2:0], lsi};
          sout_n = q[WIDTH-1];
        end
        M_HOLD: q_n = q;
        M_ROR: q_n = {q[0], q[WIDTH-1:1]};
        M_ROL: q_n = {q[WIDTH-2:0], q[WIDTH-1]};
        M_ASR: begin
          q_n    = {q[WIDTH-1], q[WIDTH-1:1]};
          sout_n = q[0];
        end
        M_INV: q_n = ~q;
        M_LDT: term_n = load;
        M_MUP: begin
          // above term the count runs on and wraps at all-ones
          q_n  = (q == term) ? ZERO : q + ONE;
          co_n = (q == term) || (q == ONES);
        end
        M_MDN: begin
          q_n  = (q == ZERO) ? term : q - ONE;
          co_n = (q == ZERO);
        end
        default: q_n = q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= RESET_VAL;
      term <= ONES;
      co   <= 1'b0;
      sout <= 1'b0;
    end else begin
      q    <= q_n;
      term <= term_n;
      co   <= co_n;
      sout <= sout_n;
    end
  end

endmodule
